// File: rtl/core_rvfi_pkg.sv
// core_rvfi_pkg: shared definitions for the RVFI retirement monitor.
//   - err_code values reported on err_code (0 means "no error")
//   - monitor FSM state encoding
//   - trace entry layout {pc, insn}, used only when RVFI_MONITOR_TRACE_EN is defined
package core_rvfi_pkg;

  localparam logic [2:0] ERR_NONE      = 3'd0;
  localparam logic [2:0] ERR_RS1       = 3'd1;
  localparam logic [2:0] ERR_RS2       = 3'd2;
  localparam logic [2:0] ERR_PC        = 3'd3;
  localparam logic [2:0] ERR_X0_WR     = 3'd4;
  localparam logic [2:0] ERR_X0_RD     = 3'd5;
  localparam logic [2:0] ERR_TRACE_OVF = 3'd6;

  typedef enum logic [1:0] {
    MON_IDLE = 2'd0,
    MON_RUN  = 2'd1,
    MON_HALT = 2'd2
  } mon_state_e;

  // Fixed at the widest supported XLEN/ILEN; narrower cores zero-extend.
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] insn;
  } trace_entry_t;

endpackage

// File: rtl/core_rvfi_trace_fifo.sv
// core_rvfi_trace_fifo: synchronous FIFO with a valid/ready output side.
// Ports:
//   g_clk, g_resetn        clock, synchronous active-low reset
//   push, push_data        write request (no back-pressure on the write side)
//   overflow               push while full and not popping; the entry is dropped
//   out_valid, out_ready   handshake: an entry leaves when out_valid && out_ready
//                          at a rising edge; out_valid is low whenever empty
//   out_data               head entry, meaningful while out_valid is high
module core_rvfi_trace_fifo #(
  parameter int W     = 96,
  parameter int DEPTH = 8
) (
  input  logic         g_clk,
  input  logic         g_resetn,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         overflow,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  // One extra pointer bit distinguishes full from empty.
  localparam int AW = $clog2(DEPTH) + 1;

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [W-1:0]  mem [DEPTH];
  logic          full;
  logic          empty;
  logic          pop;
  logic          wr;

  assign empty     = (wptr == rptr);
  assign full      = ((wptr - rptr) == AW'(DEPTH));
  assign pop       = !empty && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr        = push && (!full || pop);
  assign overflow  = push && full && !pop;
  assign out_valid = !empty;
  assign out_data  = mem[rptr[AW-2:0]];

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr)  wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge g_clk) begin
    if (wr) mem[wptr[AW-2:0]] <= push_data;
  end

endmodule

// File: rtl/core_rvfi_monitor.sv
// core_rvfi_monitor: checks each RVFI retirement against a shadow GPR file
// and the expected PC chain; counts retirements and reports errors.
// Optional trace FIFO of {pc_rdata, insn} enabled by RVFI_MONITOR_TRACE_EN.
// Ports:
//   g_clk, g_resetn         clock, synchronous active-low reset
//   rvfi_*                  retirement interface from the core (one per cycle max)
//   err_valid               one-cycle pulse per reported error (one cycle after retire)
//   err_code, err_pc        code and pc_rdata of the reported error (held until next)
//   err_sticky              set on the first error, cleared only by reset
//   mon_state               current monitor FSM state (observability)
//   retire_count            retirements accepted, wraps modulo 2^64
//   trace_valid/ready/pc/insn  trace FIFO output (RVFI_MONITOR_TRACE_EN only)
module core_rvfi_monitor
  import core_rvfi_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int ILEN        = 32,
  parameter int HALT_ON_ERR = 1,
  parameter int TRACE_DEPTH = 8
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            rvfi_valid,
  input  logic [ILEN-1:0] rvfi_insn,
  input  logic            rvfi_trap,
  input  logic            rvfi_intr,
  input  logic [4:0]      rvfi_rs1_addr,
  input  logic [4:0]      rvfi_rs2_addr,
  input  logic [XLEN-1:0] rvfi_rs1_rdata,
  input  logic [XLEN-1:0] rvfi_rs2_rdata,
  input  logic [4:0]      rvfi_rd_addr,
  input  logic [XLEN-1:0] rvfi_rd_wdata,
  input  logic [XLEN-1:0] rvfi_pc_rdata,
  input  logic [XLEN-1:0] rvfi_pc_wdata,
  output logic            err_valid,
  output logic [2:0]      err_code,
  output logic [XLEN-1:0] err_pc,
  output logic            err_sticky,
  output mon_state_e      mon_state,
  output logic [63:0]     retire_count
`ifdef RVFI_MONITOR_TRACE_EN
  ,
  output logic            trace_valid,
  input  logic            trace_ready,
  output logic [XLEN-1:0] trace_pc,
  output logic [ILEN-1:0] trace_insn
`endif
);

  logic [XLEN-1:0] shadow [32];
  logic [31:0]     shadow_vld;
  logic [XLEN-1:0] last_pc;
  logic            ovf;
  logic            rs1_bad, rs2_bad, pc_bad, x0_wr_bad, x0_rd_bad;
  logic [2:0]      code;
  logic            check_en;
  logic            err_hit;

`ifdef RVFI_MONITOR_TRACE_EN
  trace_entry_t push_entry;
  trace_entry_t pop_entry;

  always_comb begin
    push_entry      = '0;
    push_entry.pc   = 64'(rvfi_pc_rdata);
    push_entry.insn = 32'(rvfi_insn);
  end

  core_rvfi_trace_fifo #(
    .W     ($bits(trace_entry_t)),
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .push      (rvfi_valid),
    .push_data (push_entry),
    .overflow  (ovf),
    .out_valid (trace_valid),
    .out_ready (trace_ready),
    .out_data  (pop_entry)
  );

  assign trace_pc   = XLEN'(pop_entry.pc);
  assign trace_insn = ILEN'(pop_entry.insn);
`else
  logic insn_unused;
  assign insn_unused = ^rvfi_insn;
  assign ovf         = 1'b0;
`endif

  // Shadow lookups use the registered file, so a same-cycle rd==rs write is
  // checked against the old value.
  always_comb begin
    rs1_bad   = (rvfi_rs1_addr != 5'd0) && shadow_vld[rvfi_rs1_addr] &&
                (rvfi_rs1_rdata != shadow[rvfi_rs1_addr]);
    rs2_bad   = (rvfi_rs2_addr != 5'd0) && shadow_vld[rvfi_rs2_addr] &&
                (rvfi_rs2_rdata != shadow[rvfi_rs2_addr]);
    // No PC reference exists until the first retirement after reset.
    pc_bad    = (mon_state == MON_RUN) && !rvfi_intr && (rvfi_pc_rdata != last_pc);
    x0_wr_bad = (rvfi_rd_addr == 5'd0) && (rvfi_rd_wdata != '0);
    x0_rd_bad = ((rvfi_rs1_addr == 5'd0) && (rvfi_rs1_rdata != '0)) ||
                ((rvfi_rs2_addr == 5'd0) && (rvfi_rs2_rdata != '0));
    code = ERR_NONE;
    if      (rs1_bad)   code = ERR_RS1;
    else if (rs2_bad)   code = ERR_RS2;
    else if (pc_bad)    code = ERR_PC;
    else if (x0_wr_bad) code = ERR_X0_WR;
    else if (x0_rd_bad) code = ERR_X0_RD;
    else if (ovf)       code = ERR_TRACE_OVF;
  end

  assign check_en = rvfi_valid && (mon_state != MON_HALT);
  assign err_hit  = check_en && (code != ERR_NONE);

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      err_valid    <= 1'b0;
      err_code     <= ERR_NONE;
      err_pc       <= '0;
      err_sticky   <= 1'b0;
      retire_count <= '0;
      shadow_vld   <= '0;
      last_pc      <= '0;
      mon_state    <= MON_IDLE;
    end else begin
      err_valid <= err_hit;
      if (err_hit) begin
        err_code   <= code;
        err_pc     <= rvfi_pc_rdata;
        err_sticky <= 1'b1;
      end
      if (rvfi_valid) begin
        retire_count <= retire_count + 64'd1;
        last_pc      <= rvfi_pc_wdata;
        if ((rvfi_rd_addr != 5'd0) && !rvfi_trap) shadow_vld[rvfi_rd_addr] <= 1'b1;
      end
      case (mon_state)
        MON_IDLE: if (rvfi_valid)
                    mon_state <= (err_hit && (HALT_ON_ERR != 0)) ? MON_HALT : MON_RUN;
        MON_RUN:  if (err_hit && (HALT_ON_ERR != 0)) mon_state <= MON_HALT;
        default:  mon_state <= MON_HALT;
      endcase
    end
  end

  always_ff @(posedge g_clk) begin
    if (rvfi_valid && (rvfi_rd_addr != 5'd0) && !rvfi_trap)
      shadow[rvfi_rd_addr] <= rvfi_rd_wdata;
  end

endmodule

// File: tb/tb_core_rvfi_monitor.sv
// tb_core_rvfi_monitor: directed and randomized retirement streams checked
// against a behavioural model; errors and trace entries go through
// expected queues consumed by a separate monitor process.
module tb_core_rvfi_monitor;
  import core_rvfi_pkg::*;

  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam int HALT = 1;
`ifdef RVFI_MONITOR_TRACE_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 8;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic            g_clk, g_resetn;
  logic            rvfi_valid, rvfi_trap, rvfi_intr;
  logic [ILEN-1:0] rvfi_insn;
  logic [4:0]      rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
  logic [XLEN-1:0] rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
  logic [XLEN-1:0] rvfi_pc_rdata, rvfi_pc_wdata;
  logic            err_valid, err_sticky;
  logic [2:0]      err_code;
  logic [XLEN-1:0] err_pc;
  mon_state_e      mon_state;
  logic [63:0]     retire_count;
`ifdef RVFI_MONITOR_TRACE_EN
  logic            trace_valid, trace_ready;
  logic [XLEN-1:0] trace_pc;
  logic [ILEN-1:0] trace_insn;
`endif

  core_rvfi_monitor #(
    .XLEN(XLEN), .ILEN(ILEN), .HALT_ON_ERR(HALT), .TRACE_DEPTH(DEPTH)
  ) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .rvfi_valid(rvfi_valid), .rvfi_insn(rvfi_insn), .rvfi_trap(rvfi_trap),
    .rvfi_intr(rvfi_intr),
    .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
    .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
    .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
    .err_valid(err_valid), .err_code(err_code), .err_pc(err_pc),
    .err_sticky(err_sticky), .mon_state(mon_state), .retire_count(retire_count)
`ifdef RVFI_MONITOR_TRACE_EN
    , .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_insn(trace_insn)
`endif
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [66:0] exp_q[$];      // {err_code, err_pc}
  logic [95:0] trace_q[$];    // {pc, insn} in push order
  int          tq_n;          // entries the FIFO should hold

  // Reference model: architectural view of what the monitor should know.
  logic [63:0]     m_shad [32];
  bit              m_vld  [32];
  logic [63:0]     m_last_pc;
  bit              m_started, m_halted, m_err_seen;
  longint unsigned m_count;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Apply the spec's rules to whatever is on the rvfi bus this cycle.
  task automatic model_update();
    bit         pop;
    bit         full_drop;
    bit [6:1]   fired;
    logic [2:0] code;
    pop = 1'b0;
`ifdef RVFI_MONITOR_TRACE_EN
    pop = trace_ready && (tq_n > 0);
`endif
    full_drop = (tq_n == DEPTH) && !pop;
    if (rvfi_valid) begin
      fired    = '0;
      fired[1] = (rvfi_rs1_addr != 0) && m_vld[rvfi_rs1_addr] && (rvfi_rs1_rdata != m_shad[rvfi_rs1_addr]);
      fired[2] = (rvfi_rs2_addr != 0) && m_vld[rvfi_rs2_addr] && (rvfi_rs2_rdata != m_shad[rvfi_rs2_addr]);
      fired[3] = m_started && !rvfi_intr && (rvfi_pc_rdata != m_last_pc);
      fired[4] = (rvfi_rd_addr == 0) && (rvfi_rd_wdata != 0);
      fired[5] = ((rvfi_rs1_addr == 0) && (rvfi_rs1_rdata != 0)) ||
                 ((rvfi_rs2_addr == 0) && (rvfi_rs2_rdata != 0));
`ifdef RVFI_MONITOR_TRACE_EN
      fired[6] = full_drop;
`endif
      code = 3'd0;
      for (int k = 6; k >= 1; k--) if (fired[k]) code = k[2:0];
      if (!m_halted && code != 0) begin
        exp_q.push_back({code, rvfi_pc_rdata});
        m_err_seen = 1'b1;
        if (HALT != 0) m_halted = 1'b1;
      end
      if (rvfi_rd_addr != 0 && !rvfi_trap) begin
        m_shad[rvfi_rd_addr] = rvfi_rd_wdata;
        m_vld[rvfi_rd_addr]  = 1'b1;
      end
      m_last_pc = rvfi_pc_wdata;
      m_started = 1'b1;
      m_count++;
`ifdef RVFI_MONITOR_TRACE_EN
      if (!full_drop) begin
        trace_q.push_back({rvfi_pc_rdata, rvfi_insn});
        tq_n++;
      end
`endif
    end
    if (pop) tq_n--;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    model_update();
    @(posedge g_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      rvfi_valid = 1'b0;
      step();
    end
  endtask

  task automatic ret(input logic [63:0] pc, input logic [63:0] npc,
                     input logic [4:0] rs1, input logic [63:0] r1d,
                     input logic [4:0] rs2, input logic [63:0] r2d,
                     input logic [4:0] rd, input logic [63:0] wd,
                     input logic trap, input logic intr);
    rvfi_valid     = 1'b1;
    rvfi_insn      = $urandom;
    rvfi_pc_rdata  = pc;
    rvfi_pc_wdata  = npc;
    rvfi_rs1_addr  = rs1;
    rvfi_rs1_rdata = r1d;
    rvfi_rs2_addr  = rs2;
    rvfi_rs2_rdata = r2d;
    rvfi_rd_addr   = rd;
    rvfi_rd_wdata  = wd;
    rvfi_trap      = trap;
    rvfi_intr      = intr;
    step();
    rvfi_valid = 1'b0;
  endtask

  task automatic do_reset();
    g_resetn   = 1'b0;
    rvfi_valid = 1'b0;
    repeat (2) @(posedge g_clk);
    #1;
    g_resetn = 1'b1;
    for (int i = 0; i < 32; i++) m_vld[i] = 1'b0;
    m_started  = 1'b0;
    m_halted   = 1'b0;
    m_err_seen = 1'b0;
    m_count    = 0;
    m_last_pc  = '0;
    exp_q.delete();
    trace_q.delete();
    tq_n = 0;
    chk("rst_err_valid", 64'(err_valid), 64'd0);
    chk("rst_err_sticky", 64'(err_sticky), 64'd0);
    chk("rst_retire_count", retire_count, 64'd0);
    chk("rst_state", 64'(mon_state), 64'(MON_IDLE));
`ifdef RVFI_MONITOR_TRACE_EN
    chk("rst_trace_valid", 64'(trace_valid), 64'd0);
`endif
  endtask

  task automatic seg_end();
`ifdef RVFI_MONITOR_TRACE_EN
    trace_ready = 1'b1;
`endif
    idle(DEPTH + 3);
    chk("missing_err", 64'(exp_q.size()), 64'd0);
    chk("retire_count", retire_count, m_count);
    chk("err_sticky", 64'(err_sticky), 64'(m_err_seen));
`ifdef RVFI_MONITOR_TRACE_EN
    chk("trace_left", 64'(trace_q.size()), 64'd0);
`endif
  endtask

  task automatic rand_ret();
    logic [63:0] pc, npc, r1d, r2d, wd;
    logic [4:0]  rs1, rs2, rd;
    logic        intr;
`ifdef RVFI_MONITOR_TRACE_EN
    trace_ready = ($urandom_range(0, 3) != 0);
`endif
    if ($urandom_range(0, 4) == 0) idle(1);
    intr = ($urandom_range(0, 15) == 0);
    if (!m_started || intr) pc = {32'h0, $urandom} & ~64'h3;
    else                    pc = m_last_pc;
    if ($urandom_range(0, 31) == 0) pc = pc + 64'd8;
    npc = ($urandom_range(0, 3) == 0) ? (rand64() & ~64'h3) : pc + 64'd4;
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    r1d = (rs1 == 0) ? 64'd0 : (m_vld[rs1] ? m_shad[rs1] : rand64());
    r2d = (rs2 == 0) ? 64'd0 : (m_vld[rs2] ? m_shad[rs2] : rand64());
    if ($urandom_range(0, 31) == 0) r1d = r1d ^ 64'd1;
    if ($urandom_range(0, 31) == 0) r2d = r2d ^ 64'h100;
    rd = 5'($urandom_range(0, 7));
    wd = (rd == 0) ? 64'd0 : rand64();
    if (rd == 0 && $urandom_range(0, 15) == 0) wd = 64'd5;
    ret(pc, npc, rs1, r1d, rs2, r2d, rd, wd, ($urandom_range(0, 9) == 0), intr);
  endtask

  // ---------------- monitor ----------------
  logic [66:0] mon_e;
  logic [95:0] mon_t;
  always @(negedge g_clk) begin
    if (g_resetn && err_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_err: got code %0d pc 0x%0h, expected no error", err_code, err_pc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("err_code", 64'(err_code), 64'(mon_e[66:64]));
        chk("err_pc", err_pc, mon_e[63:0]);
        chk("err_sticky_on_err", 64'(err_sticky), 64'd1);
      end
    end
`ifdef RVFI_MONITOR_TRACE_EN
    if (g_resetn && trace_valid && trace_ready) begin
      if (trace_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_trace: got pc 0x%0h, expected empty FIFO", trace_pc);
      end else begin
        mon_t = trace_q.pop_front();
        chk("trace_pc", trace_pc, mon_t[95:32]);
        chk("trace_insn", 64'(trace_insn), 64'(mon_t[31:0]));
      end
    end
`endif
  end

  // ---------------- stimulus ----------------
  initial begin
    g_resetn = 1'b0;
    rvfi_valid = 1'b0; rvfi_insn = '0; rvfi_trap = 1'b0; rvfi_intr = 1'b0;
    rvfi_rs1_addr = '0; rvfi_rs2_addr = '0; rvfi_rd_addr = '0;
    rvfi_rs1_rdata = '0; rvfi_rs2_rdata = '0; rvfi_rd_wdata = '0;
    rvfi_pc_rdata = '0; rvfi_pc_wdata = '0;
`ifdef RVFI_MONITOR_TRACE_EN
    trace_ready = 1'b1;
`endif

    // Matching shadow read: no error, two retirements.
    do_reset();
    ret(64'h100, 64'h104, 0, 0, 0, 0, 5, 64'hDEAD, 0, 0);
    ret(64'h104, 64'h108, 5, 64'hDEAD, 0, 0, 0, 0, 0, 0);
    seg_end();
    chk("count_two", retire_count, 64'd2);

    // Mismatching shadow read: code 1 at the reader's pc.
    do_reset();
    ret(64'h100, 64'h104, 0, 0, 0, 0, 5, 64'hDEAD, 0, 0);
    ret(64'h104, 64'h108, 5, 64'hBEEF, 0, 0, 0, 0, 0, 0);
    seg_end();
    chk("sticky_after_rs1", 64'(err_sticky), 64'd1);

    // PC chain: interrupt entry is exempt, a plain jump is not.
    do_reset();
    ret(64'h100, 64'h104, 0, 0, 0, 0, 0, 0, 0, 0);
    ret(64'h108, 64'h10C, 0, 0, 0, 0, 0, 0, 0, 1);
    ret(64'h200, 64'h204, 0, 0, 0, 0, 0, 0, 0, 0);
    seg_end();

    // First retirement after reset has no PC check; HALT suppresses later errors.
    do_reset();
    ret(64'h8000_0000, 64'h8000_0004, 0, 0, 0, 0, 6, 64'h11, 0, 0);
    ret(64'h8000_0004, 64'h8000_0008, 0, 0, 0, 0, 0, 64'h7, 0, 0);
    ret(64'h8000_0008, 64'h8000_000C, 0, 0, 6, 64'h22, 0, 0, 0, 0);
    seg_end();
    chk("halt_state", 64'(mon_state), 64'(MON_HALT));
    chk("halt_count", retire_count, 64'd3);

    // Priority: rs1, rs2 and x0 write at once report code 1.
    do_reset();
    ret(64'h100, 64'h104, 0, 0, 0, 0, 1, 64'h1, 0, 0);
    ret(64'h104, 64'h108, 0, 0, 0, 0, 2, 64'h2, 0, 0);
    ret(64'h108, 64'h10C, 1, 64'h9, 2, 64'h9, 0, 64'h7, 0, 0);
    seg_end();

    // Trapped write leaves x3 unchecked; same-cycle rd==rs uses the old value.
    do_reset();
    ret(64'h100, 64'h400, 0, 0, 0, 0, 3, 64'h33, 1, 0);
    ret(64'h400, 64'h404, 3, 64'h99, 0, 0, 0, 0, 0, 0);
    ret(64'h404, 64'h408, 0, 0, 0, 0, 4, 64'hA, 0, 0);
    ret(64'h408, 64'h40C, 4, 64'hA, 0, 0, 4, 64'hB, 0, 0);
    ret(64'h40C, 64'h410, 4, 64'hB, 0, 0, 0, 0, 0, 0);
    seg_end();
    chk("clean_sticky", 64'(err_sticky), 64'd0);

    // Randomized segments.
    for (int s = 0; s < 16; s++) begin
      do_reset();
      repeat ($urandom_range(10, 40)) rand_ret();
      seg_end();
    end

`ifdef RVFI_MONITOR_TRACE_EN
    // Fill with the consumer stalled: fifth push overflows, then drain in order.
    do_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      ret(64'h200 + 64'(4 * i), 64'h204 + 64'(4 * i), 0, 0, 0, 0, 0, 0, 0, 0);
    chk("trace_full_valid", 64'(trace_valid), 64'd1);
    chk("trace_held", 64'(trace_q.size()), 64'd4);
    trace_ready = 1'b1;
    idle(6);
    chk("trace_drained_valid", 64'(trace_valid), 64'd0);
    seg_end();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/core_rvfi_monitor.md
Name: core_rvfi_monitor

Overview:
- Consumer end of the core's RVFI retirement interface. Watches each retired instruction and checks architectural consistency against a shadow GPR file and the expected PC chain.
- Counts retirements; reports the first and subsequent errors.
- Simulation/formal-only block, instantiated beside the core under `RVFI; never synthesised into product.

Parameters:
- XLEN, 64, data/PC width.
- ILEN, 32, instruction width.
- HALT_ON_ERR, 1, when 1 the monitor stops checking after the first error.
- TRACE_DEPTH, 8, trace FIFO entries (power of 2, >=2); used only with the optional feature.

Ports:
- g_clk  in  1  clock.
- g_resetn  in  1  reset (see Behaviour).
- rvfi_valid  in  1  retirement valid, one instruction per cycle max.
- rvfi_insn  in  ILEN  retired encoding.
- rvfi_trap  in  1  instruction trapped.
- rvfi_intr  in  1  first instruction of an interrupt/trap handler.
- rvfi_rs1_addr, rvfi_rs2_addr  in  5 each  source register indices.
- rvfi_rs1_rdata, rvfi_rs2_rdata  in  XLEN each  source values read.
- rvfi_rd_addr  in  5  destination; 0 means no write.
- rvfi_rd_wdata  in  XLEN  destination value.
- rvfi_pc_rdata, rvfi_pc_wdata  in  XLEN each  current PC / next PC.
- err_valid  out  1  one-cycle pulse per detected error.
- err_code  out  3  code of the reported error.
- err_pc  out  XLEN  pc_rdata of the offending instruction.
- err_sticky  out  1  set on first error, cleared only by reset.
- retire_count  out  64  number of retirements accepted.
- trace_valid / trace_ready / trace_pc / trace_insn: out 1 / in 1 / out XLEN / out ILEN; present only with the optional feature.

Behaviour:
- Reset g_resetn, synchronous, active-low; clock g_clk.
- Reset values: all outputs 0; all shadow-valid bits 0; FSM in IDLE.
- FSM states:
  - IDLE: no retirement seen yet. Goes to RUN on the first rvfi_valid; the PC check is skipped for that instruction.
  - RUN: full checking.
  - HALT: entered from RUN on any error when HALT_ON_ERR=1. Checks and err_valid are suppressed. retire_count still increments. Exit only by reset.
- Per retirement in IDLE/RUN, checks are evaluated combinationally from the inputs plus registered state. Results register into err_* one cycle later (latency 1).
- Error codes, lowest number reported if several fire in the same cycle:
  - 1: rs1_addr != 0, shadow[rs1] valid, and rs1_rdata != shadow value.
  - 2: same check for rs2.
  - 3: PC discontinuity. pc_rdata != last pc_wdata, with rvfi_intr=0 and state RUN.
  - 4: x0 write. rd_addr == 0 and rd_wdata != 0.
  - 5: x0 read. rs1_addr == 0 with rs1_rdata != 0, or the same for rs2.
- Shadow update: on rvfi_valid, rd_addr != 0 and rvfi_trap == 0, write shadow[rd] = rd_wdata and set its valid bit. The write is visible to checks from the next cycle onward; same-cycle rd==rs is checked against the old value.
- last_pc register loads pc_wdata on every valid retirement, including trapped ones.
- retire_count increments by 1 per rvfi_valid and wraps modulo 2^64 without error.
- err_sticky sets in the cycle err_valid first asserts.
- Reset mid-stream returns to IDLE and clears the shadow file, so the first post-reset instruction has no PC check.

Optional Feature:
- Macro: RVFI_MONITOR_TRACE_EN.
- Without it:
  - trace_* ports are absent.
  - No FIFO exists.
- With it:
  - Each valid retirement pushes {pc_rdata, insn} into a TRACE_DEPTH FIFO.
  - Output is valid/ready: an entry pops when trace_valid && trace_ready; empty FIFO deasserts trace_valid.
  - Simultaneous push and pop on a full FIFO is allowed.
  - Push when full and not popping drops the entry and raises error code 6 (reported normally, subject to priority).
  - Pointers are log2(TRACE_DEPTH)+1 bits, wrap naturally, and reset to 0.

Decomposition:
- Shared package core_rvfi_pkg holds:
  - err_code localparams ERR_RS1..ERR_TRACE_OVF;
  - monitor FSM state enum;
  - trace entry struct {pc, insn}.
- One sub-module: core_rvfi_trace_fifo, a synchronous valid/ready FIFO.

Test Plan:
- Write x5=0xDEAD, then read rs1=x5 with rdata 0xDEAD -> no err_valid; retire_count=2.
- Write x5=0xDEAD, then read rs1=x5 with rdata 0xBEEF -> err_valid for 1 cycle, err_code=1, err_pc=reader pc_rdata, err_sticky=1.
- Retire pc 0x100->0x104, then pc_rdata=0x108 with intr=0 -> err_code=3; same with intr=1 -> no error.
- Reset; first retire pc_rdata=0x8000_0000 -> no PC error. With HALT_ON_ERR=1: error, then a further rs2 mismatch -> no err_valid, retire_count still increments.
- Same cycle: rs1 mismatch, rs2 mismatch and rd_addr=0 with wdata=7 -> err_code=1 only. Trapped write x3 -> shadow x3 stays invalid, so the next x3 read is unchecked.
- TRACE_EN, TRACE_DEPTH=4, trace_ready=0: 5 retirements -> 4 entries held, err_code=6 on the 5th; then raise trace_ready -> entries drain in order, trace_valid drops after the 4th.
